regsb_scoreboard: RTL and testbench

- Parametrised, stateful register scoreboard and FU allocator for the superscalar issue stage; successor of the dual-issue combinational hazard checker.
- Keeps per-architectural-register pending bits with producing-FU tags and per-FU busy state.
- Grants in-order issue to up to ISSUE_W decoded slots per cycle, picks an FU for each granted slot, and sequences interrupt acceptance.
- Sits between decode and the exe units (ALU1/ALU2/MMU in the default configuration).

---
 rtl/regsb_pkg.sv | 18 +
 rtl/regsb_fu_alloc.sv | 35 +++
 rtl/regsb_scoreboard.sv | 151 +++++++++++++++
 tb/tb_regsb_scoreboard.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regsb_pkg.sv
// Shared constants for the issue-stage register scoreboard: FSM encoding,
// default FU indices and default sizing.
package regsb_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TAKE  = 2'd2;

  localparam int FU_ALU1 = 0;
  localparam int FU_ALU2 = 1;
  localparam int FU_MMU  = 2;

  localparam int ISSUE_W_DEF = 2;
  localparam int NFU_DEF     = 3;
  localparam int NREG_DEF    = 32;
  localparam int RA_W_DEF    = 5;

endpackage

// File: rtl/regsb_fu_alloc.sv
// Combinational priority allocator: each slot in program order takes the
// lowest-index free FU in its mask; older slots claim units first.
module regsb_fu_alloc
  import regsb_pkg::*;
#(
  parameter int ISSUE_W = ISSUE_W_DEF,
  parameter int NFU     = NFU_DEF
) (
  input  logic [NFU-1:0]         free,
  input  logic [ISSUE_W*NFU-1:0] mask,
  output logic [ISSUE_W*NFU-1:0] alloc,
  output logic [ISSUE_W-1:0]     ok
);

  logic [NFU-1:0] avail;
  logic [NFU-1:0] cand;
  logic [NFU-1:0] pick;

  always_comb begin
    avail = free;
    alloc = '0;
    ok    = '0;
    cand  = '0;
    pick  = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      cand  = avail & mask[k*NFU +: NFU];
      // Two's-complement trick isolates the lowest set bit.
      pick  = cand & (~cand + NFU'(1));
      alloc[k*NFU +: NFU] = pick;
      ok[k] = |cand;
      avail = avail & ~pick;
    end
  end

endmodule

// File: rtl/regsb_scoreboard.sv
// Stateful register scoreboard and FU allocator for the superscalar issue
// stage: pending/tag tracking, in-order grant, FU busy state, irq sequencing.
module regsb_scoreboard
  import regsb_pkg::*;
#(
  parameter int ISSUE_W = ISSUE_W_DEF,
  parameter int NFU     = NFU_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int RA_W    = RA_W_DEF,
  parameter int FU_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ISSUE_W-1:0]      slot_valid,
  input  logic [ISSUE_W*RA_W-1:0] slot_rs1,
  input  logic [ISSUE_W*RA_W-1:0] slot_rs2,
  input  logic [ISSUE_W-1:0]      slot_rs1_en,
  input  logic [ISSUE_W-1:0]      slot_rs2_en,
  input  logic [ISSUE_W*RA_W-1:0] slot_rd,
  input  logic [ISSUE_W-1:0]      slot_rd_en,
  input  logic [ISSUE_W*NFU-1:0]  slot_fu_mask,
  input  logic [ISSUE_W-1:0]      slot_serial,
  input  logic [NFU-1:0]          wb_valid,
  input  logic                    flush,
  input  logic                    irq_req,
  output logic [ISSUE_W-1:0]      issue_grant,
  output logic [ISSUE_W*NFU-1:0]  issue_fu,
  output logic                    irq_take,
  output logic [NFU-1:0]          fu_busy,
  output logic [31:0]             stall_cnt
);

  logic [NREG-1:0]        pending;
  logic [FU_W-1:0]        tag [NREG];
  logic [1:0]             state;
  logic [RA_W-1:0]        rs1 [ISSUE_W];
  logic [RA_W-1:0]        rs2 [ISSUE_W];
  logic [RA_W-1:0]        rd  [ISSUE_W];
  logic [ISSUE_W*NFU-1:0] alloc;
  logic [ISSUE_W-1:0]     alloc_ok;
  logic [ISSUE_W-1:0]     hazard;
  logic [ISSUE_W-1:0]     grant;
  logic [NFU-1:0]         issued;
  logic [NFU-1:0]         wb_eff;
  logic                   block;
  logic                   chain;

  function automatic logic [FU_W-1:0] fu_index(input logic [NFU-1:0] oh);
    logic [FU_W-1:0] idx;
    idx = '0;
    for (int f = 0; f < NFU; f++)
      if (oh[f]) idx = FU_W'(f);
    return idx;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  regsb_fu_alloc #(.ISSUE_W(ISSUE_W), .NFU(NFU)) u_alloc (
    .free  (~fu_busy),
    .mask  (slot_fu_mask),
    .alloc (alloc),
    .ok    (alloc_ok)
  );

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      rs1[k] = slot_rs1[k*RA_W +: RA_W];
      rs2[k] = slot_rs2[k*RA_W +: RA_W];
      rd[k]  = slot_rd[k*RA_W +: RA_W];
    end
  end

  // Hazards are judged against registered state only; write-back is not bypassed.
  always_comb begin
    hazard = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      hazard[k] = (slot_rs1_en[k] && pending[rs1[k]]) ||
                  (slot_rs2_en[k] && pending[rs2[k]]) ||
                  (slot_rd_en[k]  && pending[rd[k]])  ||
                  !alloc_ok[k] ||
                  (slot_serial[k] && ((k != 0) || (|fu_busy)));
      for (int j = 0; j < k; j++) begin
        if (slot_rd_en[j] && rd[j] != '0)
          hazard[k] = hazard[k] ||
                      (slot_rs1_en[k] && rs1[k] == rd[j]) ||
                      (slot_rs2_en[k] && rs2[k] == rd[j]) ||
                      (slot_rd_en[k]  && rd[k]  == rd[j]);
      end
    end
  end

  assign block = rst || flush || (state != ST_RUN) || irq_req;

  always_comb begin
    grant    = '0;
    issue_fu = '0;
    issued   = '0;
    chain    = !block;
    for (int k = 0; k < ISSUE_W; k++) begin
      chain    = chain && slot_valid[k] && !hazard[k];
      grant[k] = chain;
      issue_fu[k*NFU +: NFU] = alloc[k*NFU +: NFU] & {NFU{chain}};
      issued   = issued | issue_fu[k*NFU +: NFU];
    end
  end

  assign issue_grant = grant;
  assign wb_eff      = wb_valid & fu_busy;
  assign irq_take    = (state == ST_TAKE);

  // Write-back clears first, then issue sets, so a same-cycle issue wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      fu_busy <= '0;
      for (int r = 0; r < NREG; r++) tag[r] <= '0;
    end else if (flush) begin
      pending <= '0;
      fu_busy <= '0;
    end else begin
      fu_busy <= (fu_busy & ~wb_eff) | issued;
      for (int r = 1; r < NREG; r++)
        if (pending[r] && wb_eff[tag[r]]) pending[r] <= 1'b0;
      for (int k = 0; k < ISSUE_W; k++) begin
        if (grant[k] && slot_rd_en[k] && rd[k] != '0) begin
          pending[rd[k]] <= 1'b1;
          tag[rd[k]]     <= fu_index(alloc[k*NFU +: NFU]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      case (state)
        ST_RUN:   if (irq_req) state <= ST_DRAIN;
        ST_DRAIN: if (!irq_req) state <= ST_RUN;
                  else if (fu_busy == '0) state <= ST_TAKE;
        default:  state <= ST_RUN;
      endcase
      if (slot_valid[0] && !grant[0] && !flush)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_regsb_scoreboard.sv
// Bench for regsb_scoreboard: directed scenarios plus random traffic, all
// checked against a behavioural scoreboard model kept in the bench.
module tb_regsb_scoreboard;
  import regsb_pkg::*;

  localparam int IW = 2;
  localparam int NF = 3;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [IW-1:0]    slot_valid, slot_rs1_en, slot_rs2_en, slot_rd_en, slot_serial;
  logic [IW*RW-1:0] slot_rs1, slot_rs2, slot_rd;
  logic [IW*NF-1:0] slot_fu_mask;
  logic [NF-1:0]    wb_valid;
  logic             flush, irq_req;
  logic [IW-1:0]    issue_grant;
  logic [IW*NF-1:0] issue_fu;
  logic             irq_take;
  logic [NF-1:0]    fu_busy;
  logic [31:0]      stall_cnt;

  int tests  = 0;
  int failed = 0;

  bit          pend [32];
  int          tagm [32];
  bit [NF-1:0] busy_m;
  int          st_m;
  logic [31:0] stalls_m;
  logic [IW-1:0]    exp_grant;
  logic [IW*NF-1:0] exp_fu;

  always #5 clk = ~clk;

  regsb_scoreboard dut (
    .clk(clk), .rst(rst),
    .slot_valid(slot_valid), .slot_rs1(slot_rs1), .slot_rs2(slot_rs2),
    .slot_rs1_en(slot_rs1_en), .slot_rs2_en(slot_rs2_en),
    .slot_rd(slot_rd), .slot_rd_en(slot_rd_en),
    .slot_fu_mask(slot_fu_mask), .slot_serial(slot_serial),
    .wb_valid(wb_valid), .flush(flush), .irq_req(irq_req),
    .issue_grant(issue_grant), .issue_fu(issue_fu), .irq_take(irq_take),
    .fu_busy(fu_busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic set_slot(input int k, input bit v, input int r1, input bit e1,
                          input int r2, input bit e2, input int d, input bit ed,
                          input logic [NF-1:0] m, input bit ser);
    slot_valid[k]           = v;
    slot_rs1[k*RW +: RW]    = RW'(r1);
    slot_rs1_en[k]          = e1;
    slot_rs2[k*RW +: RW]    = RW'(r2);
    slot_rs2_en[k]          = e2;
    slot_rd[k*RW +: RW]     = RW'(d);
    slot_rd_en[k]           = ed;
    slot_fu_mask[k*NF +: NF] = m;
    slot_serial[k]          = ser;
  endtask

  task automatic idle();
    set_slot(0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    set_slot(1, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    wb_valid = '0;
    flush    = 1'b0;
  endtask

  // Expected grants: walk slots oldest first, stop at the first that cannot go.
  task automatic model_eval();
    bit stop;
    bit wr [32];
    bit [NF-1:0] used, avail;
    int pick, r1, r2, d;
    exp_grant = '0;
    exp_fu    = '0;
    used      = '0;
    foreach (wr[i]) wr[i] = 1'b0;
    stop = flush || st_m != 0 || irq_req;
    for (int k = 0; k < IW; k++) begin
      r1 = int'(slot_rs1[k*RW +: RW]);
      r2 = int'(slot_rs2[k*RW +: RW]);
      d  = int'(slot_rd[k*RW +: RW]);
      if (!slot_valid[k]) stop = 1;
      if (slot_rs1_en[k] && (pend[r1] || wr[r1])) stop = 1;
      if (slot_rs2_en[k] && (pend[r2] || wr[r2])) stop = 1;
      if (slot_rd_en[k]  && (pend[d]  || wr[d]))  stop = 1;
      if (slot_serial[k] && (k != 0 || busy_m != 0)) stop = 1;
      avail = slot_fu_mask[k*NF +: NF] & ~busy_m & ~used;
      pick = -1;
      for (int f = NF - 1; f >= 0; f--) if (avail[f]) pick = f;
      if (pick < 0) stop = 1;
      if (!stop) begin
        exp_grant[k] = 1'b1;
        exp_fu[k*NF + pick] = 1'b1;
        used[pick] = 1'b1;
        if (slot_rd_en[k] && d != 0) wr[d] = 1'b1;
      end
    end
  endtask

  task automatic model_clock();
    bit [NF-1:0] busy_old;
    int d;
    busy_old = busy_m;
    case (st_m)
      0: if (irq_req) st_m = 1;
      1: if (!irq_req) st_m = 0; else if (busy_old == 0) st_m = 2;
      default: st_m = 0;
    endcase
    if (slot_valid[0] && !exp_grant[0] && !flush && stalls_m != 32'hFFFF_FFFF)
      stalls_m = stalls_m + 1;
    if (flush) begin
      foreach (pend[i]) pend[i] = 1'b0;
      busy_m = '0;
    end else begin
      for (int f = 0; f < NF; f++) begin
        if (wb_valid[f] && busy_old[f]) begin
          busy_m[f] = 1'b0;
          for (int r = 0; r < 32; r++) if (tagm[r] == f) pend[r] = 1'b0;
        end
      end
      for (int k = 0; k < IW; k++) begin
        for (int f = 0; f < NF; f++) begin
          if (exp_grant[k] && exp_fu[k*NF + f]) begin
            busy_m[f] = 1'b1;
            d = int'(slot_rd[k*RW +: RW]);
            if (slot_rd_en[k] && d != 0) begin
              pend[d] = 1'b1;
              tagm[d] = f;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle(input string nm, input int eg = -1, input int ef = -1, input int et = -1);
    model_eval();
    @(negedge clk);
    chk({nm, ".grant"}, 64'(issue_grant), 64'(exp_grant));
    chk({nm, ".fu"},    64'(issue_fu),    64'(exp_fu));
    chk({nm, ".take"},  64'(irq_take),    64'(st_m == 2));
    chk({nm, ".busy"},  64'(fu_busy),     64'(busy_m));
    chk({nm, ".stall"}, 64'(stall_cnt),   64'(stalls_m));
    if (eg >= 0) chk({nm, ".grant_dir"}, 64'(issue_grant), 64'(eg));
    if (ef >= 0) chk({nm, ".fu_dir"},    64'(issue_fu),    64'(ef));
    if (et >= 0) chk({nm, ".take_dir"},  64'(irq_take),    64'(et));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drain();
    idle();
    wb_valid = '1;
    cycle("drain");
    wb_valid = '0;
  endtask

  initial begin
    logic [NF-1:0] m0, m1;
    foreach (pend[i]) begin pend[i] = 1'b0; tagm[i] = 0; end
    busy_m = '0; st_m = 0; stalls_m = '0;
    irq_req = 1'b0;
    idle();
    set_slot(0, 1, 1, 1, 0, 0, 2, 1, 3'b001, 0);

    // Outputs must read zero while reset is held, even with a valid slot.
    #1 rst = 1'b1;
    #2;
    chk("rst.grant", 64'(issue_grant), 64'd0);
    chk("rst.fu",    64'(issue_fu),    64'd0);
    chk("rst.take",  64'(irq_take),    64'd0);
    chk("rst.busy",  64'(fu_busy),     64'd0);
    chk("rst.stall", 64'(stall_cnt),   64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Intra-bundle RAW on x5, then stall until write-back of ALU1.
    set_slot(0, 1, 0, 0, 0, 0, 5, 1, 3'b011, 0);
    set_slot(1, 1, 5, 1, 0, 0, 6, 1, 3'b011, 0);
    cycle("p1a", 1, 6'b000_001);
    set_slot(0, 1, 5, 1, 0, 0, 6, 1, 3'b011, 0);
    set_slot(1, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    cycle("p1b", 0);
    cycle("p1c", 0);
    wb_valid = 3'b001;
    cycle("p1d", 0);
    wb_valid = '0;
    cycle("p1e", 1, 6'b000_001);
    drain();

    // MMU-only bundle: one grant, then structural stall counting.
    m0 = NF'(1) << FU_MMU;
    set_slot(0, 1, 0, 0, 0, 0, 0, 0, m0, 0);
    set_slot(1, 1, 0, 0, 0, 0, 0, 0, m0, 0);
    cycle("p2a", 1, 6'b000_100);
    cycle("p2b", 0);
    cycle("p2c", 0);
    cycle("p2d", 0);
    drain();

    // x7 re-targeted from FU1 to FU0; idle write-back on FU1 must not clear it.
    m0 = NF'(1) << FU_ALU2;
    m1 = NF'(1) << FU_ALU1;
    set_slot(0, 1, 0, 0, 0, 0, 7, 1, m0, 0);
    cycle("p3a", 1, 6'b000_010);
    set_slot(0, 1, 0, 0, 0, 0, 7, 1, m1, 0);
    wb_valid = 3'b010;
    cycle("p3b", 0);
    wb_valid = '0;
    cycle("p3c", 1, 6'b000_001);
    set_slot(0, 1, 7, 1, 0, 0, 0, 0, 3'b100, 0);
    wb_valid = 3'b010;
    cycle("p3d", 0);
    wb_valid = 3'b001;
    cycle("p3e", 0);
    wb_valid = '0;
    cycle("p3f", 1, 6'b000_100);
    drain();

    // Interrupt drains a busy MMU before the take pulse.
    set_slot(0, 1, 0, 0, 0, 0, 0, 0, 3'b100, 0);
    cycle("p4a", 1);
    irq_req = 1'b1;
    set_slot(0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 0);
    for (int i = 0; i < 4; i++) cycle("p4b", 0, -1, 0);
    wb_valid = 3'b100;
    cycle("p4c", 0, -1, 0);
    wb_valid = '0;
    cycle("p4d", 0, -1, 0);
    irq_req = 1'b0;
    cycle("p4e", 0, -1, 1);
    cycle("p4f", 1, -1, 0);
    drain();

    // Flush with x3/x4 pending and every FU busy.
    set_slot(0, 1, 0, 0, 0, 0, 3, 1, 3'b001, 0);
    set_slot(1, 1, 0, 0, 0, 0, 4, 1, 3'b010, 0);
    cycle("p5a", 3, 6'b010_001);
    set_slot(0, 1, 0, 0, 0, 0, 0, 0, 3'b100, 0);
    set_slot(1, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    cycle("p5b", 1, 6'b000_100);
    set_slot(0, 1, 3, 1, 0, 0, 0, 0, 3'b001, 0);
    flush = 1'b1;
    cycle("p5c", 0);
    flush = 1'b0;
    cycle("p5d", 1, 6'b000_001);
    drain();

    // x0 as source and destination never creates a dependency.
    set_slot(0, 1, 0, 1, 0, 0, 0, 1, 3'b001, 0);
    set_slot(1, 1, 0, 1, 0, 1, 0, 1, 3'b010, 0);
    cycle("p6a", 3, 6'b010_001);
    set_slot(0, 1, 0, 1, 0, 1, 0, 1, 3'b100, 0);
    set_slot(1, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    cycle("p6b", 1, 6'b000_100);
    drain();

    // Serial instructions: only in slot 0 and only with all FUs idle.
    set_slot(0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 1);
    set_slot(1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 1);
    cycle("s1", 1);
    set_slot(0, 1, 0, 0, 0, 0, 0, 0, 3'b010, 1);
    set_slot(1, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    cycle("s2", 0);
    drain();

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < IW; k++)
        set_slot(k, ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 NF'($urandom_range(1, 7)), ($urandom_range(0, 15) == 0));
      wb_valid = NF'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 39) == 0) irq_req = ~irq_req;
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
